eg_limiter_pipe: RTL and testbench
==================================

EG_LIMITER_PIPE -- requirements
Module: eg_limiter_pipe

Interface
REQ-001 Parameter SLOTS, default 24, number of time-multiplexed operator slots (2..64).
REQ-002 Parameter EGW, default 10, envelope width in bits.
REQ-003 Parameter TLW, default 7, total-level width in bits (TLW+3 <= EGW).
REQ-004 clk  in  1  system clock; the block has one clock only.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 cen  in  1  clock enable; pipeline and slot counter advance only when high.
REQ-007 lfo_mod  in  7  global LFO AM phase, shared by all slots.
REQ-008 eg_pure_in  in  EGW  raw envelope of the slot indicated by cur_slot.
REQ-009 ssg_inv  in  1  SSG inversion flag for the current slot.
REQ-010 wr_en, wr_slot[5:0], wr_tl[TLW-1:0], wr_ams[1:0], wr_amsen  in  per-slot configuration write port.
REQ-011 cur_slot  out  6  slot being sampled this cycle.
REQ-012 eg_limited  out  EGW  limited attenuation; out_slot  out  6  its slot; out_valid  out  1  qualifier.

Function
REQ-013 cur_slot SHALL increment on each cen-high cycle and wrap from SLOTS-1 to 0.
REQ-014 Stage 1 (registered on cen) SHALL capture: eg_pream = ssg_inv ? (2^(EGW-1) - eg_pure_in) mod 2^EGW : eg_pure_in; am_final; tl of cur_slot; the slot number.
REQ-015 am_inv = lfo_mod[6] ? ~lfo_mod[5:0] : lfo_mod[5:0].
REQ-016 am_final by {amsen,ams}: amsen=0 or ams=00 -> 0; 01 -> am_inv>>2; 10 -> am_inv; 11 -> am_inv<<1; zero-extended to EGW+2 bits.
REQ-017 Stage 2 (registered on cen) SHALL compute sum = (tl << (EGW-TLW)) + eg_pream + am_final in EGW+2 bits with no overflow.
REQ-018 eg_limited SHALL be sum[EGW-1:0] when sum[EGW+1:EGW]==0, else all ones.
REQ-019 Latency: exactly 2 cen-high cycles from sampling to eg_limited/out_slot/out_valid.
REQ-020 out_valid SHALL go high on the second cen-high cycle after reset and then remain high.
REQ-021 cen low: all pipeline registers, outputs and cur_slot hold their values.
REQ-022 Writes SHALL be accepted on any cycle with wr_en high, independent of cen; wr_slot >= SLOTS is ignored.
REQ-023 A write to the slot read by stage 1 in the same cycle SHALL NOT affect that sample; it takes effect from the next read.

Reset
REQ-024 While rst_n is low at a clk edge: cur_slot=0, out_valid=0, eg_limited=all ones, out_slot=0.
REQ-025 The same reset SHALL clear the pipeline registers and set all slot entries to tl=all ones, ams=0, amsen=0.
REQ-026 Reset mid-operation discards in-flight samples; no stale out_valid after rst_n rises.

Configuration
REQ-027 Macro EG_LIMITER_SAT_CNT_EN, when defined, adds output sat_cnt[15:0], which counts cen-high stage-2 saturations, sticks at 0xFFFF and is cleared by reset.
REQ-028 Without EG_LIMITER_SAT_CNT_EN, the sat_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package eg_limiter_pkg SHALL hold the ams encoding constants, the slot-index width (6) and the saturation-count width.
REQ-030 Sub-module eg_limiter_cfg_ram SHALL hold the per-slot register file, with one write port and one read port; all other logic stays in the top level.

Verification
REQ-031 Configure slot 0 with tl=0x10, amsen=0; drive eg=0x050, ssg_inv=0 -> eg_limited=0x0D0, out_slot=0, two cycles later.
REQ-032 Slot 3 with tl=0, amsen=1, ams=11, lfo_mod=0x45; drive eg=0x100 -> am_inv=0x3A, eg_limited=0x174.
REQ-033 tl=0x7F, eg=0x3FF -> sum overflow, eg_limited=0x3FF; with the macro defined, sat_cnt increments by 1.
REQ-034 ssg_inv=1, eg=0x050, tl=0, amsen=0 -> eg_limited=0x1B0; ssg_inv=1, eg=0x300 -> wrapped pream 0x300 -> eg_limited=0x300.
REQ-035 Toggle cen low for 5 cycles mid-stream, then assert rst_n low for 1 cycle -> outputs hold while cen is low; after reset, out_valid=0 and eg_limited=0x3FF, and cur_slot restarts at 0 and wraps 23->0.

Source files
------------

// File: rtl/eg_limiter_pkg.sv
// Shared definitions for the envelope limiter pipeline: slot index width,
// saturation counter width, AM sensitivity encoding and the LFO AM fold helper.
package eg_limiter_pkg;

  localparam int unsigned SLOT_W    = 6;
  localparam int unsigned SAT_CNT_W = 16;
  localparam int unsigned LFO_W     = 7;
  localparam int unsigned AM_INV_W  = 6;

  // AM sensitivity: off, quarter depth, nominal depth, double depth
  typedef enum logic [1:0] {
    AMS_OFF     = 2'b00,
    AMS_QUARTER = 2'b01,
    AMS_HALF    = 2'b10,
    AMS_DOUBLE  = 2'b11
  } ams_e;

  // Fold the 7-bit LFO phase into a 6-bit triangle
  function automatic logic [AM_INV_W-1:0] am_invert(input logic [LFO_W-1:0] lfo);
    return lfo[LFO_W-1] ? ~lfo[AM_INV_W-1:0] : lfo[AM_INV_W-1:0];
  endfunction

endpackage

// File: rtl/eg_limiter_if.sv
// Limiter bus: per-slot envelope sample in, limited attenuation out, and the
// per-slot configuration write port.
//   master : drives lfo_mod, eg_pure_in, ssg_inv, wr_* ; receives cur_slot,
//            eg_limited, out_slot, out_valid
//   slave  : the limiter pipeline (opposite directions)
interface eg_limiter_if #(
  parameter int unsigned EGW = 10,
  parameter int unsigned TLW = 7
);

  logic [eg_limiter_pkg::LFO_W-1:0]  lfo_mod;
  logic [EGW-1:0]                    eg_pure_in;
  logic                              ssg_inv;
  logic                              wr_en;
  logic [eg_limiter_pkg::SLOT_W-1:0] wr_slot;
  logic [TLW-1:0]                    wr_tl;
  logic [1:0]                        wr_ams;
  logic                              wr_amsen;
  logic [eg_limiter_pkg::SLOT_W-1:0] cur_slot;
  logic [EGW-1:0]                    eg_limited;
  logic [eg_limiter_pkg::SLOT_W-1:0] out_slot;
  logic                              out_valid;

  modport master (
    output lfo_mod, eg_pure_in, ssg_inv, wr_en, wr_slot, wr_tl, wr_ams, wr_amsen,
    input  cur_slot, eg_limited, out_slot, out_valid
  );

  modport slave (
    input  lfo_mod, eg_pure_in, ssg_inv, wr_en, wr_slot, wr_tl, wr_ams, wr_amsen,
    output cur_slot, eg_limited, out_slot, out_valid
  );

endinterface

// File: rtl/eg_limiter_cfg_ram.sv
// Per-slot configuration register file (tl, ams, amsen).
// One synchronous write port (ignored for wr_slot >= SLOTS) and one
// asynchronous read port, so a same-cycle write is seen from the next read.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_slot/wr_tl/wr_ams/wr_amsen,
//        rd_slot -> rd_tl_c/rd_ams_c/rd_amsen_c.
module eg_limiter_cfg_ram
  import eg_limiter_pkg::*;
#(
  parameter int unsigned SLOTS = 24,
  parameter int unsigned TLW   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [TLW-1:0]    wr_tl,
  input  logic [1:0]        wr_ams,
  input  logic              wr_amsen,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [TLW-1:0]    rd_tl_c,
  output logic [1:0]        rd_ams_c,
  output logic              rd_amsen_c
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [TLW-1:0] tl_mem    [SLOTS];
  logic [1:0]     ams_mem   [SLOTS];
  logic           amsen_mem [SLOTS];

  logic wr_ok_c;
  logic rd_ok_c;

  assign wr_ok_c = wr_en && (32'(wr_slot) < SLOTS);
  assign rd_ok_c = 32'(rd_slot) < SLOTS;

  // Reset loads max attenuation with AM disabled in every slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        tl_mem[i]    <= '1;
        ams_mem[i]   <= AMS_OFF;
        amsen_mem[i] <= 1'b0;
      end
    end else if (wr_ok_c) begin
      tl_mem[wr_slot[IDX_W-1:0]]    <= wr_tl;
      ams_mem[wr_slot[IDX_W-1:0]]   <= wr_ams;
      amsen_mem[wr_slot[IDX_W-1:0]] <= wr_amsen;
    end
  end

  // Out-of-range reads return the reset contents
  always_comb begin
    rd_tl_c    = '1;
    rd_ams_c   = AMS_OFF;
    rd_amsen_c = 1'b0;
    if (rd_ok_c) begin
      rd_tl_c    = tl_mem[rd_slot[IDX_W-1:0]];
      rd_ams_c   = ams_mem[rd_slot[IDX_W-1:0]];
      rd_amsen_c = amsen_mem[rd_slot[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/eg_limiter_pipe.sv
// Two-stage envelope limiter for SLOTS time-multiplexed operator slots.
// Stage 1 samples the current slot's envelope (with optional SSG inversion),
// its AM contribution and its total level; stage 2 sums them and clamps to
// all ones. Everything advances only on cen.
// Ports: clk, rst_n (sync, active-low), cen, bus (eg_limiter_if.slave),
//        sat_cnt (only when EG_LIMITER_SAT_CNT_EN is defined).
module eg_limiter_pipe
  import eg_limiter_pkg::*;
#(
  parameter int unsigned SLOTS = 24,
  parameter int unsigned EGW   = 10,
  parameter int unsigned TLW   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  eg_limiter_if.slave bus
`ifdef EG_LIMITER_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

  localparam int unsigned SUMW      = EGW + 2;
  localparam logic [EGW-1:0] EG_HALF = {1'b1, {(EGW-1){1'b0}}};
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  logic [TLW-1:0]      rd_tl_c;
  logic [1:0]          rd_ams_c;
  logic                rd_amsen_c;
  logic [EGW-1:0]      pream_c;
  logic [AM_INV_W-1:0] am_inv_c;
  logic [SUMW-1:0]     am_final_c;
  logic [SUMW-1:0]     sum_c;
  logic                sat_c;

  logic [EGW-1:0]      s1_pream;
  logic [SUMW-1:0]     s1_am;
  logic [TLW-1:0]      s1_tl;
  logic [SLOT_W-1:0]   s1_slot;
  logic                s1_valid;

  eg_limiter_cfg_ram #(
    .SLOTS (SLOTS),
    .TLW   (TLW)
  ) u_cfg_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.wr_en),
    .wr_slot    (bus.wr_slot),
    .wr_tl      (bus.wr_tl),
    .wr_ams     (bus.wr_ams),
    .wr_amsen   (bus.wr_amsen),
    .rd_slot    (bus.cur_slot),
    .rd_tl_c    (rd_tl_c),
    .rd_ams_c   (rd_ams_c),
    .rd_amsen_c (rd_amsen_c)
  );

  // Stage-1 inputs: SSG inversion wraps modulo 2^EGW, AM scaled by sensitivity
  always_comb begin
    pream_c = bus.eg_pure_in;
    if (bus.ssg_inv) begin
      pream_c = EG_HALF - bus.eg_pure_in;
    end
    am_inv_c   = am_invert(bus.lfo_mod);
    am_final_c = '0;
    if (rd_amsen_c) begin
      case (ams_e'(rd_ams_c))
        AMS_QUARTER: am_final_c = SUMW'(am_inv_c >> 2);
        AMS_HALF:    am_final_c = SUMW'(am_inv_c);
        AMS_DOUBLE:  am_final_c = SUMW'({am_inv_c, 1'b0});
        default:     am_final_c = '0;
      endcase
    end
  end

  // Stage-2 sum is wide enough that it cannot wrap; top bits flag saturation
  always_comb begin
    sum_c = SUMW'({s1_tl, {(EGW-TLW){1'b0}}}) + SUMW'(s1_pream) + s1_am;
    sat_c = |sum_c[SUMW-1:EGW];
  end

  // Slot counter and both pipeline stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cur_slot   <= '0;
      s1_pream       <= '0;
      s1_am          <= '0;
      s1_tl          <= '0;
      s1_slot        <= '0;
      s1_valid       <= 1'b0;
      bus.eg_limited <= '1;
      bus.out_slot   <= '0;
      bus.out_valid  <= 1'b0;
    end else if (cen) begin
      bus.cur_slot   <= (bus.cur_slot == LAST_SLOT) ? '0 : bus.cur_slot + SLOT_W'(1);
      s1_pream       <= pream_c;
      s1_am          <= am_final_c;
      s1_tl          <= rd_tl_c;
      s1_slot        <= bus.cur_slot;
      s1_valid       <= 1'b1;
      bus.eg_limited <= sat_c ? '1 : sum_c[EGW-1:0];
      bus.out_slot   <= s1_slot;
      bus.out_valid  <= s1_valid;
    end
  end

`ifdef EG_LIMITER_SAT_CNT_EN
  // Sticky saturation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cen && sat_c && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_eg_limiter_pipe.sv
// Self-checking bench for eg_limiter_pipe: constant vector table, hand-written
// sequences for write/read collisions, cen stalls and reset, and randomized
// traffic against an arithmetic reference model.
module tb_eg_limiter_pipe;

  localparam int unsigned SLOTS = 24;
  localparam int unsigned EGW   = 10;
  localparam int unsigned TLW   = 7;
  localparam int EG_MAX = (1 << EGW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;

  always #5 clk = ~clk;

  eg_limiter_if #(.EGW(EGW), .TLW(TLW)) bus_if ();

`ifdef EG_LIMITER_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  eg_limiter_pipe #(
    .SLOTS (SLOTS),
    .EGW   (EGW),
    .TLW   (TLW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus_if)
`ifdef EG_LIMITER_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    bit v;
    int val;
    int slot;
    bit sat;
  } exp_t;

  typedef struct {
    int slot;
    int tl;
    int ams;
    int amsen;
    int lfo;
    int eg;
    int ssg;
    int exp;
  } vec_t;

  exp_t pipe_q[$];
  exp_t out_exp;
  int   m_tl    [SLOTS];
  int   m_ams   [SLOTS];
  int   m_amsen [SLOTS];
  int   m_slot;
  int   m_sat;

  vec_t vecs [11];

  // Limited attenuation straight from the arithmetic definition
  function automatic int ref_att(input int tl, input int ams, input int amsen,
                                 input int lfo, input int eg, input int ssg,
                                 output bit sat);
    int pream, ainv, am, sum;
    pream = (ssg != 0) ? (((1 << (EGW - 1)) - eg) + (1 << EGW)) % (1 << EGW) : eg;
    ainv  = (lfo >= 64) ? 63 - (lfo - 64) : lfo;
    am    = 0;
    if (amsen != 0) begin
      case (ams)
        1: am = ainv / 4;
        2: am = ainv;
        3: am = ainv * 2;
        default: am = 0;
      endcase
    end
    sum = tl * (1 << (EGW - TLW)) + pream + am;
    sat = (sum > EG_MAX);
    return sat ? EG_MAX : sum;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    exp_t bubble;
    m_slot = 0;
    m_sat  = 0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      m_tl[i]    = (1 << TLW) - 1;
      m_ams[i]   = 0;
      m_amsen[i] = 0;
    end
    bubble = '{v: 1'b0, val: 0, slot: 0, sat: 1'b0};
    pipe_q = {};
    pipe_q.push_back(bubble);
    out_exp = '{v: 1'b0, val: EG_MAX, slot: 0, sat: 1'b0};
  endtask

  task automatic check_outputs();
    chk("cur_slot", int'(bus_if.cur_slot), m_slot);
    chk("eg_limited", int'(bus_if.eg_limited), out_exp.val);
    chk("out_slot", int'(bus_if.out_slot), out_exp.slot);
    chk("out_valid", int'(bus_if.out_valid), int'(out_exp.v));
`ifdef EG_LIMITER_SAT_CNT_EN
    chk("sat_cnt", int'(sat_cnt), m_sat);
`endif
  endtask

  // One clock: check at negedge, drive, advance model at posedge
  task automatic step(input bit c, input bit we, input int ws, input int tl,
                      input int ams, input int amsen, input int lfo,
                      input int eg, input int ssg);
    exp_t e;
    bit   s;
    check_outputs();
    cen               = c;
    bus_if.wr_en      = we;
    bus_if.wr_slot    = 6'(ws);
    bus_if.wr_tl      = 7'(tl);
    bus_if.wr_ams     = 2'(ams);
    bus_if.wr_amsen   = 1'(amsen);
    bus_if.lfo_mod    = 7'(lfo);
    bus_if.eg_pure_in = 10'(eg);
    bus_if.ssg_inv    = 1'(ssg);
    @(posedge clk);
    if (c) begin
      e.val  = ref_att(m_tl[m_slot], m_ams[m_slot], m_amsen[m_slot], lfo, eg, ssg, s);
      e.v    = 1'b1;
      e.slot = m_slot;
      e.sat  = s;
      out_exp = pipe_q.pop_front();
      pipe_q.push_back(e);
      if (out_exp.sat && m_sat < 65535) m_sat++;
      m_slot = (m_slot + 1) % int'(SLOTS);
    end
    if (we && ws < int'(SLOTS)) begin
      m_tl[ws]    = tl;
      m_ams[ws]   = ams;
      m_amsen[ws] = amsen;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < int'(SLOTS) && m_slot != s; i++) idle();
  endtask

  // Sample slot s (optionally writing it in the same cycle), check 2 cycles later
  task automatic sample_chk(input string name, input int s, input int lfo,
                            input int eg, input int ssg, input bit we,
                            input int wtl, input int exp);
    goto_slot(s);
    step(1'b1, we, s, wtl, 0, 0, lfo, eg, ssg);
    idle();
    chk({name, "_val"}, int'(bus_if.eg_limited), exp);
    chk({name, "_slot"}, int'(bus_if.out_slot), s);
    chk({name, "_vld"}, int'(bus_if.out_valid), 1);
  endtask

  task automatic do_reset();
    check_outputs();
    rst_n        = 1'b0;
    cen          = 1'b1;
    bus_if.wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{slot: 0,  tl: 'h10, ams: 0, amsen: 0, lfo: 'h00, eg: 'h050, ssg: 0, exp: 'h0D0};
    vecs[1]  = '{slot: 3,  tl: 'h00, ams: 3, amsen: 1, lfo: 'h45, eg: 'h100, ssg: 0, exp: 'h174};
    vecs[2]  = '{slot: 5,  tl: 'h7F, ams: 0, amsen: 0, lfo: 'h00, eg: 'h3FF, ssg: 0, exp: 'h3FF};
    vecs[3]  = '{slot: 7,  tl: 'h00, ams: 0, amsen: 0, lfo: 'h00, eg: 'h050, ssg: 1, exp: 'h1B0};
    vecs[4]  = '{slot: 9,  tl: 'h00, ams: 0, amsen: 0, lfo: 'h00, eg: 'h300, ssg: 1, exp: 'h300};
    vecs[5]  = '{slot: 23, tl: 'h01, ams: 1, amsen: 1, lfo: 'h20, eg: 'h010, ssg: 0, exp: 'h020};
    vecs[6]  = '{slot: 1,  tl: 'h00, ams: 3, amsen: 0, lfo: 'h3F, eg: 'h000, ssg: 0, exp: 'h000};
    vecs[7]  = '{slot: 2,  tl: 'h00, ams: 2, amsen: 1, lfo: 'h7F, eg: 'h3FF, ssg: 0, exp: 'h3FF};
    vecs[8]  = '{slot: 4,  tl: 'h00, ams: 2, amsen: 1, lfo: 'h01, eg: 'h3FF, ssg: 0, exp: 'h3FF};
    vecs[9]  = '{slot: 6,  tl: 'h7F, ams: 0, amsen: 0, lfo: 'h00, eg: 'h006, ssg: 0, exp: 'h3FE};
    vecs[10] = '{slot: 11, tl: 'h05, ams: 1, amsen: 1, lfo: 'h4C, eg: 'h1F0, ssg: 1, exp: 'h044};

    bus_if.wr_en      = 1'b0;
    bus_if.wr_slot    = '0;
    bus_if.wr_tl      = '0;
    bus_if.wr_ams     = '0;
    bus_if.wr_amsen   = 1'b0;
    bus_if.lfo_mod    = '0;
    bus_if.eg_pure_in = '0;
    bus_if.ssg_inv    = 1'b0;

    // Power-on reset and output latency
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("por_valid", int'(bus_if.out_valid), 0);
    chk("por_eg", int'(bus_if.eg_limited), EG_MAX);
    chk("por_slot", int'(bus_if.cur_slot), 0);
    idle();
    chk("lat1_valid", int'(bus_if.out_valid), 0);
    idle();
    chk("lat2_valid", int'(bus_if.out_valid), 1);
    chk("lat2_eg", int'(bus_if.eg_limited), 'h3F8);

    // Constant vector table
    foreach (vecs[i]) begin
      step(1'b1, 1'b1, vecs[i].slot, vecs[i].tl, vecs[i].ams, vecs[i].amsen, 0, 0, 0);
      sample_chk($sformatf("vec%0d", i), vecs[i].slot, vecs[i].lfo, vecs[i].eg,
                 vecs[i].ssg, 1'b0, 0, vecs[i].exp);
    end

    // Write to the slot being read in the same cycle: old value used, new value next time
    step(1'b1, 1'b1, 10, 0, 0, 0, 0, 0, 0);
    sample_chk("wr_same", 10, 0, 'h020, 0, 1'b1, 'h40, 'h020);
    sample_chk("wr_next", 10, 0, 'h020, 0, 1'b0, 0, 'h220);

    // Out-of-range write slot must not alias onto slot 8
    step(1'b1, 1'b1, 8, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 40, 'h7F, 0, 0, 0, 0, 0);
    sample_chk("wr_oor", 8, 0, 'h011, 0, 1'b0, 0, 'h011);

    // Randomized traffic, including writes while cen is low
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 63)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1)));
    end

    // cen stall mid-stream, then reset
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 0, int'($urandom_range(0, 127)),
           int'($urandom_range(0, 1023)), 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 0, 0, 0, 0, int'($urandom_range(0, 127)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
    end
    do_reset();
    chk("rst_valid", int'(bus_if.out_valid), 0);
    chk("rst_eg", int'(bus_if.eg_limited), EG_MAX);
    chk("rst_slot", int'(bus_if.cur_slot), 0);
    chk("rst_out_slot", int'(bus_if.out_slot), 0);
    for (int i = 0; i < int'(SLOTS) - 1; i++) idle();
    chk("slot_last", int'(bus_if.cur_slot), int'(SLOTS) - 1);
    idle();
    chk("slot_wrap", int'(bus_if.cur_slot), 0);

    check_outputs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
